// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controller: light codes, phase
// durations and the phase-timer state encoding.
package traffic_pkg;

    typedef enum logic [1:0] {
        LIGHT_RED    = 2'd0,
        LIGHT_YELLOW = 2'd1,
        LIGHT_GREEN  = 2'd2
    } light_e;

    // Phase lengths in seconds, loaded by the traffic-light FSM
    localparam int unsigned T_BASE = 6;
    localparam int unsigned T_EXT  = 3;
    localparam int unsigned T_YEL  = 2;
    localparam int unsigned T_WALK = 3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/clk_prescaler.sv
// Divides the board clock down to a one-cycle strobe per elapsed second.
module clk_prescaler #(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt;

    // Counter rests at 0 whenever disabled so every phase starts a full second
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || !en || (cnt == CNT_MAX)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Wrap strobe; the timer registers it before it leaves the block
    assign tick = en && !clear && (cnt == CNT_MAX);

endmodule

// File: rtl/traffic_phase_timer.sv
// Times controller-loaded light phases in whole seconds and latches the
// pedestrian walk request until acknowledged.
module traffic_phase_timer
    import traffic_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned DUR_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DUR_W-1:0] duration,
    input  logic             walkButton,
    input  logic             walk_ack,
    output logic             busy,
    output logic             expire,
    output logic             tick_1hz,
    output logic [DUR_W-1:0] remaining,
    output logic             walk_pending
);

    logic [0:0]       state;
    logic [0:0]       state_n;
    logic [DUR_W-1:0] remaining_n;
    logic             busy_n;
    logic             expire_n;
    logic             tick_n;
    logic             walk_n;
    logic             ps_tick;

    clk_prescaler #(
        .CLK_HZ (CLK_HZ)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (start),
        .en    (busy),
        .tick  (ps_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            remaining    <= '0;
            busy         <= 1'b0;
            expire       <= 1'b0;
            tick_1hz     <= 1'b0;
            walk_pending <= 1'b0;
        end else begin
            state        <= state_n;
            remaining    <= remaining_n;
            busy         <= busy_n;
            expire       <= expire_n;
            tick_1hz     <= tick_n;
            walk_pending <= walk_n;
        end
    end

    // busy stays high through the expire cycle so a back-to-back start leaves no gap
    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        busy_n      = (state == ST_RUN);
        expire_n    = 1'b0;
        tick_n      = 1'b0;
        walk_n      = walkButton ? 1'b1 : (walk_ack ? 1'b0 : walk_pending);

        if (start) begin
            // A (re)start discards any tick or expire of the phase being replaced
            remaining_n = duration;
            if (duration != '0) begin
                state_n = ST_RUN;
                busy_n  = 1'b1;
            end else begin
                state_n  = ST_IDLE;
                busy_n   = 1'b0;
                expire_n = 1'b1;
            end
        end else if ((state == ST_RUN) && ps_tick) begin
            tick_n      = 1'b1;
            remaining_n = (remaining != '0) ? (remaining - DUR_W'(1)) : '0;
            if (remaining == DUR_W'(1)) begin
                expire_n = 1'b1;
                state_n  = ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Directed plus randomized bench for traffic_phase_timer against an
// elapsed-time reference model of the phase and walk behaviour.
module tb_traffic_phase_timer;

    localparam int unsigned C     = 4;
    localparam int unsigned DUR_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [DUR_W-1:0] duration;
    logic             walkButton;
    logic             walk_ack;
    logic             busy;
    logic             expire;
    logic             tick_1hz;
    logic [DUR_W-1:0] remaining;
    logic             walk_pending;

    int n_vec = 0;
    int n_err = 0;
    int n_exp_seen = 0;

    // Reference model: a loaded phase is described by its length and the
    // number of clock edges elapsed since the start edge.
    bit m_act   = 1'b0;
    int m_d     = 0;
    int m_since = 0;
    bit m_zexp  = 1'b0;
    bit m_walk  = 1'b0;

    traffic_phase_timer #(
        .CLK_HZ (C),
        .DUR_W  (DUR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .duration     (duration),
        .walkButton   (walkButton),
        .walk_ack     (walk_ack),
        .busy         (busy),
        .expire       (expire),
        .tick_1hz     (tick_1hz),
        .remaining    (remaining),
        .walk_pending (walk_pending)
    );

    always #5 clk = ~clk;

    function automatic bit exp_expire();
        return (m_act && (m_since == m_d * int'(C))) || m_zexp;
    endfunction

    function automatic bit exp_tick();
        return m_act && (m_since > 0) && ((m_since % int'(C)) == 0);
    endfunction

    function automatic int exp_remaining();
        return m_act ? (m_d - m_since / int'(C)) : 0;
    endfunction

    task automatic model_edge();
        m_zexp = 1'b0;
        if (!rst) begin
            m_act  = 1'b0;
            m_d    = 0;
            m_walk = 1'b0;
        end else begin
            if (start) begin
                if (duration != '0) begin
                    m_act   = 1'b1;
                    m_d     = int'(duration);
                    m_since = 0;
                end else begin
                    m_act  = 1'b0;
                    m_zexp = 1'b1;
                end
            end else if (m_act) begin
                m_since++;
                if (m_since > m_d * int'(C)) m_act = 1'b0;
            end
            if (walkButton)    m_walk = 1'b1;
            else if (walk_ack) m_walk = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        if (expire === 1'b1) n_exp_seen++;
        chk("busy",         32'(busy),         32'(m_act));
        chk("expire",       32'(expire),       32'(exp_expire()));
        chk("tick_1hz",     32'(tick_1hz),     32'(exp_tick()));
        chk("remaining",    32'(remaining),    32'(exp_remaining()));
        chk("walk_pending", 32'(walk_pending), 32'(m_walk));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        duration   = '0;
        walkButton = 1'b0;
        walk_ack   = 1'b0;

        // Reset held for three cycles, then released into idle
        run(3);
        rst = 1'b1;
        run(3);

        // Basic phase, D=3
        start = 1'b1; duration = 4'd3; step(); start = 1'b0;
        run(14);

        // Zero duration
        start = 1'b1; duration = 4'd0; step(); start = 1'b0;
        run(4);

        // Restart: D=2 replaced by D=1 six edges later
        n_exp_seen = 0;
        start = 1'b1; duration = 4'd2; step(); start = 1'b0;
        run(5);
        start = 1'b1; duration = 4'd1; step(); start = 1'b0;
        run(8);
        chk("restart_expire_count", 32'(n_exp_seen), 32'd1);

        // Back-to-back: new start sampled at the end of the expire cycle
        start = 1'b1; duration = 4'd1; step(); start = 1'b0;
        for (int i = 0; i < 12 && !exp_expire(); i++) step();
        chk("b2b_expire_reached", 32'(exp_expire()), 32'd1);
        n_exp_seen = 0;
        start = 1'b1; duration = 4'd1; step(); start = 1'b0;
        run(8);
        chk("b2b_second_expire_count", 32'(n_exp_seen), 32'd1);

        // Walk latch: set, set-wins, clear
        walkButton = 1'b1; step(); walkButton = 1'b0;
        step();
        walkButton = 1'b1; walk_ack = 1'b1; step();
        walkButton = 1'b0; step();
        walk_ack = 1'b0; step();

        // Reset mid-phase aborts without expire
        walkButton = 1'b1; start = 1'b1; duration = 4'd5; step();
        start = 1'b0; walkButton = 1'b0;
        run(6);
        rst = 1'b0; step(); rst = 1'b1;
        n_exp_seen = 0;
        run(25);
        chk("post_reset_expire_count", 32'(n_exp_seen), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            start      = ($urandom_range(0, 15) == 0);
            duration   = DUR_W'($urandom_range(0, 5));
            walkButton = ($urandom_range(0, 9) == 0);
            walk_ack   = ($urandom_range(0, 5) == 0);
            rst        = ($urandom_range(0, 249) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/traffic_phase_timer.md
# traffic_phase_timer

Phase-duration sequencer for the intersection controller. It converts the board clock into 1-second ticks and times each light phase the controller loads, e.g. base green, extension and yellow, with a one-cycle `expire` pulse at the end. It also latches the asynchronous-to-phase walk request until the controller acknowledges it. It sits between the board inputs and the traffic-light FSM, which only issues `start`/`duration` and reacts to `expire`.

## Interface
- `CLK_HZ`, default 100_000_000: input clock frequency; one second equals `CLK_HZ` cycles.
- `DUR_W`, default 4: width of phase duration in seconds (max 15 s).
- `clk`, in, 1: single system clock, rising edge.
- `rst`, in, 1: reset. Synchronous and active-low.
- `start`, in, 1: load `duration` and begin timing a phase.
- `duration`, in, `DUR_W`: phase length in seconds. Sampled only when `start`=1.
- `walkButton`, in, 1: pedestrian request, level, already synchronised to `clk`.
- `walk_ack`, in, 1: controller has served the walk request.
- `busy`, out, 1: a phase is being timed.
- `expire`, out, 1: one-cycle pulse at the end of the phase.
- `tick_1hz`, out, 1: one-cycle pulse per elapsed second while `busy`.
- `remaining`, out, `DUR_W`: whole seconds left in the current phase, for display/debug.
- `walk_pending`, out, 1: latched walk request.

## Operation
- **States:** IDLE and RUN, encoded as 1 bit.
- **IDLE:**
  - `busy`=0 and the prescaler is held at 0.
  - `start` with D≥1 loads `remaining`=D, clears the prescaler and moves to RUN.
  - `start` with D=0 pulses `expire` the next cycle and stays in IDLE.
- **RUN:**
  - The prescaler counts 0..`CLK_HZ`-1. At `CLK_HZ`-1 it wraps to 0, pulses `tick_1hz` and decrements `remaining`.
  - The tick that takes `remaining` from 1 to 0 also pulses `expire`, and the state returns to IDLE.
- **`start` during RUN:** the phase restarts. The new D is loaded, the prescaler is cleared and any tick or expire of the aborted phase in that cycle is suppressed.
  - Exception: `start` in the exact cycle `expire` is high. The old phase's `expire` is still emitted and the new phase loads normally.
- **Walk latch:**
  - `walkButton`=1 sets `walk_pending`.
  - `walk_ack`=1 clears it.
  - If both are high in the same cycle, set wins.
  - The latch operates independently of the IDLE/RUN state.
- **Arithmetic:** `remaining` is unsigned `DUR_W` bits and never underflows. The prescaler width is ceil(log2(`CLK_HZ`)).
- **Reset (`rst`=0 at a rising edge):**
  - All outputs go to 0: `busy`, `expire`, `tick_1hz`, `remaining`, `walk_pending`.
  - The prescaler goes to 0 and the state to IDLE.
  - A phase in progress is aborted with no `expire`.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- **Phase latency:** with `start` sampled at edge E0, `busy` is 1 from E0 onward.
  - The first `tick_1hz` is high in the cycle following edge E0+`CLK_HZ`.
  - `expire` is high for exactly the cycle following edge E0+D·`CLK_HZ`.
  - `busy` is 0 one edge after that.
- **D=0:** `expire` is high in the cycle after E0. `busy` stays 0 and no tick occurs.
- **`remaining`:** updates on the same edge that raises `tick_1hz`.
- **`walk_pending`:** rises one edge after `walkButton` is sampled high and falls one edge after `walk_ack` is sampled high.

## Structure
- **Shared package `traffic_pkg`** holds:
  - the light encodings (RED/YELLOW/GREEN on 2 bits);
  - the phase durations in seconds (T_BASE=6, T_EXT=3, T_YEL=2, T_WALK=3);
  - the IDLE/RUN encoding.
  - The traffic-light FSM imports these too.
- **Sub-module `clk_prescaler`** (parameter `CLK_HZ`; ports `clk`, `rst`, `clear`, `en`, `tick`) generates the 1 Hz strobe. The timer instantiates it with `en`=`busy` and `clear`=`start`.

## Test plan
All scenarios use `CLK_HZ`=4 for simulation speed.
- **Reset values:** hold `rst`=0 for 3 cycles → every output is 0. Release → the block stays IDLE with `busy`=0.
- **Basic phase:** `start`, D=3 → `busy`=1; `tick_1hz` at cycles 4, 8 and 12 after start; `remaining` 3→2→1→0; `expire` only at cycle 12; `busy`=0 at cycle 13.
- **Zero duration:** `start`, D=0 → `expire` high at cycle 1 only; `busy` and `tick_1hz` never high.
- **Restart:** `start` D=2, then `start` D=1 at cycle 6 → no expire at cycle 8; a single `expire` at cycle 10.
- **Back-to-back:** `start` D=1 asserted in the `expire` cycle → the old `expire` is seen once, the new phase expires 4 cycles later, and `busy` has no gap.
- **Walk latch and reset:** `walkButton` pulse → `walk_pending`=1. `walk_ack` and `walkButton` high together → stays 1. `walk_ack` alone → 0. `rst`=0 mid-phase (D=5, cycle 7) → `remaining`=0 and `busy`=0, with no `expire` afterwards.
